// File: rtl/iomem_dbg_bridge.sv
// iomem_dbg_bridge: turns a debug command byte stream into 32-bit iomem
// bus transactions and returns the response as a byte stream.
//   'W' a3 a2 a1 a0 d3 d2 d1 d0 -> write, reply 'K'
//   'R' a3 a2 a1 a0             -> read, reply rdata MSB first
//   other first byte            -> reply '?'
//   bus timeout                 -> reply 'T'
module iomem_dbg_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        err_overrun,
    output logic        busy
);

    // Counter only ever reaches TIMEOUT-1 before it is cleared, so it never wraps.
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              op_write_reg;
    logic [1:0]        byte_cnt_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       resp_word_reg;
    logic [1:0]        resp_left_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              overrun_reg;

    logic rx_fire;
    logic tx_fire;
    logic bus_done;
    logic bus_timeout;

    assign rx_fire     = rx_valid && rx_ready;
    assign tx_fire     = (state_reg == S_RESP) && tx_ready;
    // Ready wins over the timeout when both land on the same edge.
    assign bus_done    = (state_reg == S_BUS) && iomem_ready;
    assign bus_timeout = (state_reg == S_BUS) && !iomem_ready && (wait_cnt_reg == WAIT_LAST);

    // State register; reset abandons any transaction at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode from accepted bytes, bus completion and tx handshakes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        state_next = S_ADDR;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire && byte_cnt_reg == 2'd3) begin
                    state_next = op_write_reg ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                if (rx_fire && byte_cnt_reg == 2'd3) begin
                    state_next = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_done || bus_timeout) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_fire && resp_left_reg == 2'd0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; the bus request is the BUS state itself.
    always_comb begin
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        iomem_valid = 1'b0;
        busy        = 1'b1;
        case (state_reg)
            S_IDLE: begin
                rx_ready = 1'b1;
                busy     = 1'b0;
            end
            S_ADDR, S_DATA: rx_ready    = 1'b1;
            S_BUS:          iomem_valid = 1'b1;
            S_RESP:         tx_valid    = 1'b1;
            default:        busy        = 1'b1;
        endcase
        tx_data     = tx_valid ? resp_word_reg[31:24] : 8'h00;
        iomem_wstrb = (iomem_valid && op_write_reg) ? 4'hF : 4'h0;
    end

    assign iomem_addr  = addr_reg;
    assign iomem_wdata = wdata_reg;
    assign err_overrun = overrun_reg;

    // Datapath: command capture, wait counting, response staging and overrun flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_write_reg  <= 1'b0;
            byte_cnt_reg  <= 2'd0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            resp_word_reg <= 32'h0;
            resp_left_reg <= 2'd0;
            wait_cnt_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (rx_valid && !rx_ready) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    byte_cnt_reg <= 2'd0;
                    wait_cnt_reg <= '0;
                    if (rx_fire) begin
                        op_write_reg  <= (rx_data == CMD_WRITE);
                        resp_word_reg <= {RSP_UNKNOWN, 24'h0};
                        resp_left_reg <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_reg     <= {addr_reg[23:0], rx_data};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        wdata_reg    <= {wdata_reg[23:0], rx_data};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        wait_cnt_reg <= '0;
                        if (op_write_reg) begin
                            resp_word_reg <= {RSP_OK, 24'h0};
                            resp_left_reg <= 2'd0;
                        end else begin
                            resp_word_reg <= iomem_rdata;
                            resp_left_reg <= 2'd3;
                        end
                    end else if (bus_timeout) begin
                        wait_cnt_reg  <= '0;
                        resp_word_reg <= {RSP_TIMEOUT, 24'h0};
                        resp_left_reg <= 2'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (tx_fire && resp_left_reg != 2'd0) begin
                        resp_word_reg <= resp_word_reg << 8;
                        resp_left_reg <= resp_left_reg - 2'd1;
                    end
                end
                default: byte_cnt_reg <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_dbg_bridge.sv
// Testbench for iomem_dbg_bridge: a behavioural responder with a sparse memory
// sits on the bus; expected replies come from a command-level reference model.
module tb_iomem_dbg_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata = 32'h0;
    logic        err_overrun;
    logic        busy;

    iomem_dbg_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .err_overrun(err_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Responder state and bus observations.
    logic [31:0] resp_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    int          resp_wait = 0;
    int          vcnt = 0;
    int          mon_cycles = 0;
    bit          mon_unstable = 1'b0;
    logic [31:0] mon_addr;
    logic [31:0] mon_wdata;
    logic [3:0]  mon_wstrb;

    // Collected and expected reply bytes.
    logic [7:0]  got_b [4];
    int          got_n = 0;
    logic [7:0]  exp_b [4];
    int          exp_n = 0;
    int          exp_cyc = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    // Responder: asserts ready on valid-cycle resp_wait+1, records bus fields.
    always @(negedge clk) begin
        if (!resetn || !iomem_valid) begin
            vcnt        = 0;
            iomem_ready = 1'b0;
        end else begin
            vcnt++;
            if (vcnt == 1) begin
                mon_addr  = iomem_addr;
                mon_wdata = iomem_wdata;
                mon_wstrb = iomem_wstrb;
            end else if (iomem_addr !== mon_addr || iomem_wdata !== mon_wdata || iomem_wstrb !== mon_wstrb) begin
                mon_unstable = 1'b1;
            end
            mon_cycles  = vcnt;
            iomem_ready = (vcnt == resp_wait + 1);
            if (iomem_ready) begin
                iomem_rdata = resp_mem.exists(iomem_addr) ? resp_mem[iomem_addr] : dflt(iomem_addr);
                if (iomem_wstrb == 4'hF) resp_mem[iomem_addr] = iomem_wdata;
            end else begin
                iomem_rdata = $urandom;
            end
        end
    end

    // Reference model: reply bytes and bus occupancy for one command.
    task automatic model_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input int wt);
        logic [31:0] v;
        if (wt >= TO) begin
            exp_n = 1; exp_b[0] = 8'h54; exp_cyc = TO;
        end else begin
            exp_cyc = wt + 1;
            if (w) begin
                ref_mem[a] = d;
                exp_n = 1; exp_b[0] = 8'h4B;
            end else begin
                v = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                exp_n = 4;
                for (int i = 0; i < 4; i++) exp_b[i] = v[31-8*i -: 8];
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_byte: rx_ready=%b want 1 after %0d cycles", rx_ready, n);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input int wt);
        resp_wait    = wt;
        mon_cycles   = 0;
        mon_unstable = 1'b0;
        mon_addr     = 'x;
        mon_wdata    = 'x;
        mon_wstrb    = 'x;
        send_byte(w ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
        if (w) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
    endtask

    task automatic collect_resp(input int n_want);
        int n = 0;
        got_n    = 0;
        tx_ready = 1'b1;
        while (got_n < n_want && n < 400) begin
            if (tx_valid) begin
                got_b[got_n] = tx_data;
                got_n++;
            end
            @(negedge clk);
            n++;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || iomem_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: rx_ready=%b tx_valid=%b iomem_valid=%b busy=%b want 1 0 0 0",
                     rx_ready, tx_valid, iomem_valid, busy);
        end
        total++;
        if (iomem_addr !== 32'h0 || iomem_wdata !== 32'h0 || iomem_wstrb !== 4'h0 || tx_data !== 8'h00 || err_overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h tx_data=%h err=%b want all 0",
                     iomem_addr, iomem_wdata, iomem_wstrb, tx_data, err_overrun);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [31:0] a, d;
        int wt;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                a = 32'h0300_0000; d = 32'h0000_00A5; wt = 2;
            end else begin
                a = $urandom; d = $urandom; wt = $urandom_range(0, TO - 2);
            end
            model_cmd(1'b1, a, d, wt);
            send_cmd(1'b1, a, d, wt);
            collect_resp(exp_n);
            total++;
            if (got_n !== exp_n || got_b[0] !== exp_b[0]) begin
                bad++;
                $display("FAIL write_resp[%0d]: got n=%0d byte=%h want n=%0d byte=%h", k, got_n, got_b[0], exp_n, exp_b[0]);
            end
            total++;
            if (mon_addr !== a || mon_wdata !== d || mon_wstrb !== 4'hF) begin
                bad++;
                $display("FAIL write_bus[%0d]: addr=%h wdata=%h wstrb=%h want %h %h f", k, mon_addr, mon_wdata, mon_wstrb, a, d);
            end
            total++;
            if (mon_cycles !== exp_cyc || mon_unstable) begin
                bad++;
                $display("FAIL write_valid[%0d]: cycles=%0d unstable=%b want %0d 0", k, mon_cycles, mon_unstable, exp_cyc);
            end
            total++;
            if (busy !== 1'b0 || tx_valid !== 1'b0) begin
                bad++;
                $display("FAIL write_idle[%0d]: busy=%b tx_valid=%b want 0 0", k, busy, tx_valid);
            end
        end
    endtask

    task automatic test_read();
        logic [31:0] a, got_w, exp_w;
        int wt;
        resp_mem[32'h0200_0004] = 32'h1234_5678;
        ref_mem[32'h0200_0004]  = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                a = 32'h0200_0004; wt = 3;
            end else begin
                a = (k % 2 == 0) ? 32'h0300_0000 : $urandom; wt = $urandom_range(0, TO - 2);
            end
            model_cmd(1'b0, a, 32'h0, wt);
            send_cmd(1'b0, a, 32'h0, wt);
            collect_resp(exp_n);
            got_w = {got_b[0], got_b[1], got_b[2], got_b[3]};
            exp_w = {exp_b[0], exp_b[1], exp_b[2], exp_b[3]};
            total++;
            if (got_n !== 4 || got_w !== exp_w) begin
                bad++;
                $display("FAIL read_resp[%0d]: got n=%0d data=%h want n=4 data=%h", k, got_n, got_w, exp_w);
            end
            total++;
            if (mon_addr !== a || mon_wstrb !== 4'h0 || mon_cycles !== exp_cyc || mon_unstable) begin
                bad++;
                $display("FAIL read_bus[%0d]: addr=%h wstrb=%h cycles=%0d unstable=%b want %h 0 %0d 0",
                         k, mon_addr, mon_wstrb, mon_cycles, mon_unstable, a, exp_cyc);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a, got_w, exp_w;
        a = 32'h0400_0010;
        // Ready never comes: aborted after exactly TO valid cycles.
        model_cmd(1'b0, a, 32'h0, 1000);
        send_cmd(1'b0, a, 32'h0, 1000);
        collect_resp(exp_n);
        total++;
        if (got_n !== 1 || got_b[0] !== 8'h54 || mon_cycles !== TO) begin
            bad++;
            $display("FAIL timeout_abort: n=%0d byte=%h cycles=%0d want 1 54 %0d", got_n, got_b[0], mon_cycles, TO);
        end
        // Ready in the very cycle the count would expire: success.
        model_cmd(1'b0, a, 32'h0, TO - 1);
        send_cmd(1'b0, a, 32'h0, TO - 1);
        collect_resp(exp_n);
        got_w = {got_b[0], got_b[1], got_b[2], got_b[3]};
        exp_w = {exp_b[0], exp_b[1], exp_b[2], exp_b[3]};
        total++;
        if (got_n !== 4 || got_w !== exp_w || mon_cycles !== TO) begin
            bad++;
            $display("FAIL timeout_edge: n=%0d data=%h cycles=%0d want 4 %h %0d", got_n, got_w, mon_cycles, exp_w, TO);
        end
        // Write that times out leaves memory untouched; a following read proves it.
        model_cmd(1'b1, a, 32'hDEAD_0001, 1000);
        send_cmd(1'b1, a, 32'hDEAD_0001, 1000);
        collect_resp(exp_n);
        model_cmd(1'b0, a, 32'h0, 0);
        send_cmd(1'b0, a, 32'h0, 0);
        collect_resp(exp_n);
        got_w = {got_b[0], got_b[1], got_b[2], got_b[3]};
        exp_w = {exp_b[0], exp_b[1], exp_b[2], exp_b[3]};
        total++;
        if (got_n !== 4 || got_w !== exp_w || mon_cycles !== 1) begin
            bad++;
            $display("FAIL timeout_after: n=%0d data=%h cycles=%0d want 4 %h 1", got_n, got_w, mon_cycles, exp_w);
        end
    endtask

    task automatic test_unknown_backpressure();
        logic [7:0] b;
        int held_bad = 0;
        tx_ready = 1'b0;
        send_byte(8'h41);
        for (int i = 0; i < 10; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h3F || busy !== 1'b1) held_bad++;
            @(negedge clk);
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL unknown_hold: %0d of 10 cycles lost tx_valid/tx_data=3f, last tx_valid=%b tx_data=%h",
                     held_bad, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL unknown_release: tx_valid=%b busy=%b rx_ready=%b want 0 0 1", tx_valid, busy, rx_ready);
        end
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h57 || b == 8'h52) b = 8'h00;
            send_byte(b);
            collect_resp(1);
            total++;
            if (got_n !== 1 || got_b[0] !== 8'h3F) begin
                bad++;
                $display("FAIL unknown_byte %h: n=%0d byte=%h want 1 3f", b, got_n, got_b[0]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] a, got_w, exp_w;
        int n = 0;
        a = 32'h0500_0020;
        model_cmd(1'b0, a, 32'h0, 5);
        send_cmd(1'b0, a, 32'h0, 5);
        while (!iomem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (iomem_valid !== 1'b1 || rx_ready !== 1'b0 || err_overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_pre: iomem_valid=%b rx_ready=%b err=%b want 1 0 0", iomem_valid, rx_ready, err_overrun);
        end
        rx_data  = 8'h57;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        collect_resp(exp_n);
        got_w = {got_b[0], got_b[1], got_b[2], got_b[3]};
        exp_w = {exp_b[0], exp_b[1], exp_b[2], exp_b[3]};
        total++;
        if (got_n !== 4 || got_w !== exp_w || mon_cycles !== 6 || err_overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_txn: n=%0d data=%h cycles=%0d err=%b want 4 %h 6 1", got_n, got_w, mon_cycles, err_overrun, exp_w);
        end
        model_cmd(1'b1, a, 32'h0BAD_F00D, 1);
        send_cmd(1'b1, a, 32'h0BAD_F00D, 1);
        collect_resp(exp_n);
        total++;
        if (got_n !== 1 || got_b[0] !== 8'h4B || err_overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: n=%0d byte=%h err=%b want 1 4b 1", got_n, got_b[0], err_overrun);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] a, d;
        int n = 0;
        send_cmd(1'b0, 32'h0600_0000, 32'h0, 1000);
        while (!iomem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (iomem_valid !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1 || err_overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: iomem_valid=%b tx_valid=%b busy=%b rx_ready=%b err=%b want 0 0 0 1 0",
                     iomem_valid, tx_valid, busy, rx_ready, err_overrun);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        a = $urandom; d = $urandom;
        model_cmd(1'b1, a, d, 2);
        send_cmd(1'b1, a, d, 2);
        collect_resp(exp_n);
        total++;
        if (got_n !== 1 || got_b[0] !== 8'h4B || mon_addr !== a || mon_wdata !== d) begin
            bad++;
            $display("FAIL reset_recover: n=%0d byte=%h addr=%h wdata=%h want 1 4b %h %h", got_n, got_b[0], mon_addr, mon_wdata, a, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d, got_w, exp_w;
        bit w;
        int wt;
        int mism = 0;
        int not_ready = 0;
        for (int k = 0; k < 24; k++) begin
            w  = ($urandom_range(0, 1) == 1);
            a  = 32'h0200_0000 + 32'(4 * $urandom_range(0, 5));
            d  = $urandom;
            wt = (k % 6 == 5) ? 1000 : $urandom_range(0, TO - 1);
            if (rx_ready !== 1'b1) not_ready++;
            model_cmd(w, a, d, wt);
            send_cmd(w, a, d, wt);
            collect_resp(exp_n);
            got_w = {got_b[0], got_b[1], got_b[2], got_b[3]};
            exp_w = {exp_b[0], exp_b[1], exp_b[2], exp_b[3]};
            if (exp_n == 1) begin
                got_w[23:0] = 24'h0;
                exp_w[23:0] = 24'h0;
            end
            if (got_n !== exp_n || got_w !== exp_w || mon_cycles !== exp_cyc || mon_unstable) begin
                mism++;
                $display("FAIL b2b[%0d] w=%0b a=%h wt=%0d: n=%0d data=%h cycles=%0d want n=%0d data=%h cycles=%0d",
                         k, w, a, wt, got_n, got_w, mon_cycles, exp_n, exp_w, exp_cyc);
            end
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL b2b_summary: %0d mismatching transactions want 0", mism);
        end
        total++;
        if (not_ready != 0) begin
            bad++;
            $display("FAIL b2b_ready: rx_ready low after last handshake %0d times want 0", not_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_unknown_backpressure();
        test_overrun();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/iomem_dbg_bridge.md
Name: iomem_dbg_bridge

Overview:
Byte-stream-to-iomem bus initiator for debug access to peripheral registers. It accepts a command byte stream, typically received UART bytes, and decodes read and write commands. It then drives 32-bit iomem transactions toward the iomem responders (GPIO, UART registers, ...) and returns response bytes on a valid/ready byte output. It is the initiator counterpart to the iomem address-decode responders in the SoC top level.

Parameters:
TIMEOUT, 255, max cycles iomem_valid stays high without iomem_ready before the transaction is aborted (1..65535)

Ports:
clk  input  1  system clock; all state changes on its rising edge
resetn  input  1  reset, asynchronous, active-low
rx_data  input  8  received command byte
rx_valid  input  1  one-cycle strobe: rx_data valid
rx_ready  output  1  high when the bridge can accept a byte this cycle
tx_data  output  8  response byte
tx_valid  output  1  response byte valid
tx_ready  input  1  sink accepts tx_data
iomem_valid  output  1  bus request
iomem_ready  input  1  responder completion, may be combinational
iomem_wstrb  output  4  byte enables; 4'b1111 for write, 4'b0000 for read
iomem_addr  output  32  bus address
iomem_wdata  output  32  write data
iomem_rdata  input  32  read data, sampled when iomem_valid && iomem_ready
err_overrun  output  1  sticky: a byte arrived while rx_ready was low
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (resetn low, async): state IDLE. All outputs 0 except rx_ready = 1. Address, data and counters cleared. Reset mid-operation abandons the transaction immediately; iomem_valid drops asynchronously.
- rx_ready = 1 in IDLE, ADDR and DATA; 0 in BUS and RESP.
- Byte accepted on a rising edge with rx_valid && rx_ready.
- rx_valid && !rx_ready: byte discarded, err_overrun <= 1, held until reset.
- IDLE:
  - 0x57 'W' -> ADDR, op=write.
  - 0x52 'R' -> ADDR, op=read.
  - Any other byte -> RESP with single reply byte 0x3F '?'.
- ADDR: 4 bytes, MSB first; the address shifts left 8 per byte. After the 4th byte: write -> DATA; read -> BUS.
- DATA: 4 bytes, MSB first, shifted into wdata. After the 4th byte -> BUS.
- BUS:
  - iomem_valid = 1 the cycle after entry.
  - addr, wdata and wstrb are stable for the whole time valid is high.
  - Completion is the rising edge where iomem_valid && iomem_ready. On that edge: rdata is captured, iomem_valid <= 0 and the state goes to RESP.
  - Minimum bus occupancy is 1 cycle when ready is already high.
  - A wait counter increments each valid-high cycle without ready. When it reaches TIMEOUT with ready still low: iomem_valid <= 0, abort, RESP with single byte 0x54 'T'.
  - If ready arrives in the same cycle the counter hits TIMEOUT, it counts as success; ready wins.
- RESP:
  - tx_valid = 1 and tx_data holds steady until tx_ready is sampled high.
  - Responses: write OK -> 1 byte 0x4B 'K'; read OK -> 4 bytes, rdata MSB first; timeout -> 0x54; unknown command -> 0x3F.
  - After the last byte is accepted: tx_valid <= 0, state IDLE, rx_ready = 1 on the next cycle.
  - tx_ready may be held low indefinitely; there is no timeout in RESP.
- Back-to-back: a new command byte may be accepted on the cycle after the last tx handshake.
- Widths: the wait counter is wide enough for TIMEOUT; it does not wrap.

Test Plan:
- Write: rx 57 03 00 00 00 00 00 00 A5 -> one bus cycle, addr=0x03000000, wdata=0x000000A5, wstrb=1111, valid held until ready; tx 4B.
- Read: rx 52 02 00 00 04, responder returns 0x12345678 after 3 wait cycles -> wstrb=0000, valid high 4 cycles; tx 12 34 56 78 in order.
- Timeout: TIMEOUT=8, rx 52 + 4 addr bytes, ready held low -> valid high exactly 8 cycles then low; tx 54; next command works normally.
- Unknown plus backpressure: rx 41, tx_ready low for 10 cycles -> tx_valid high with tx_data=3F stable throughout; accepted when tx_ready rises; busy falls on the next cycle.
- Overrun: pulse rx_valid during BUS -> byte dropped, transaction unaffected, err_overrun=1 and stays 1 after later commands.
- Reset mid-read: assert resetn low while iomem_valid=1 -> iomem_valid, tx_valid and busy drop immediately. After release, a full write completes with tx 4B.
